player_move_ctrl: RTL and testbench

Sequencing controller for the game player sprite datapath. Synchronizes and debounces the four raw direction buttons and a start button, arbitrates them into a single direction, and generates the `move_clock` strobe that steps the sprite position. Runs a run/pause state machine so the sprite freezes while paused. Sits between the board push-buttons and the player sprite block; its outputs drive that block's `left`, `right`, `up`, `down` and `move_clock` inputs directly.

---
 rtl/player_move_ctrl.sv | 170 +++++++++++++++++
 tb/tb_player_move_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_move_ctrl.sv
// rtl/player_move_ctrl.sv - button sync/debounce, first-pressed arbiter, run/pause FSM and move_clock divider
// Optional debounce counters: define PLAYER_CTRL_DEBOUNCE_EN (otherwise debounced level = synchronizer output).
module player_move_ctrl #(
  parameter int DEBOUNCE_CYC = 500000,
  parameter int MOVE_DIV     = 250000,
  parameter int CNT_W        = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_start,
  output logic       left,
  output logic       right,
  output logic       up,
  output logic       down,
  output logic       move_clock,
  output logic [2:0] dir_code,
  output logic       running
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(MOVE_DIV - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(MOVE_DIV - 2);
  localparam logic [CNT_W-1:0] DIV_FALL = CNT_W'(MOVE_DIV / 2 - 1);

  // bit order: 0 left, 1 right, 2 up, 3 down, 4 start
  logic [4:0] btn_raw;
  logic [4:0] sync1;
  logic [4:0] sync2;
  logic [4:0] db_lvl;

  assign btn_raw = {btn_start, btn_down, btn_up, btn_right, btn_left};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

`ifdef PLAYER_CTRL_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [CNT_W-1:0] db_cnt [5];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_lvl <= '0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_lvl[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign db_lvl = sync2;
`endif

  // First-pressed arbiter: a live owner keeps the grant, otherwise fixed priority picks
  logic [3:0] held;
  logic       owner_vld;
  logic [1:0] owner_idx;
  logic       arb_vld;
  logic [1:0] arb_idx;

  assign held = db_lvl[3:0];

  always_comb begin
    arb_vld = owner_vld & held[owner_idx];
    arb_idx = owner_idx;
    if (!arb_vld) begin
      arb_vld = |held;
      if (held[0])      arb_idx = 2'd0;
      else if (held[1]) arb_idx = 2'd1;
      else if (held[2]) arb_idx = 2'd2;
      else if (held[3]) arb_idx = 2'd3;
      else              arb_idx = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_vld <= 1'b0;
      owner_idx <= 2'd0;
    end else begin
      owner_vld <= arb_vld;
      owner_idx <= arb_idx;
    end
  end

  state_t state;
  state_t state_nxt;
  logic   start_prev;
  logic   start_rise;

  assign start_rise = db_lvl[4] & ~start_prev;

  always_comb begin
    state_nxt = state;
    if (start_rise) begin
      case (state)
        IDLE:    state_nxt = RUN;
        RUN:     state_nxt = PAUSE;
        PAUSE:   state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      start_prev <= 1'b0;
      running    <= 1'b0;
    end else begin
      state      <= state_nxt;
      start_prev <= db_lvl[4];
      running    <= (state_nxt == RUN);
    end
  end

  logic [CNT_W-1:0] div_cnt;
  logic             step_vld;

  assign step_vld = arb_vld && (state == RUN);

  // Directions load one cycle before move_clock rises so they are stable on its edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt    <= '0;
      move_clock <= 1'b0;
      left       <= 1'b0;
      right      <= 1'b0;
      up         <= 1'b0;
      down       <= 1'b0;
      dir_code   <= 3'b100;
    end else begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      if (div_cnt == DIV_LAST)      move_clock <= 1'b1;
      else if (div_cnt == DIV_FALL) move_clock <= 1'b0;
      if (div_cnt == DIV_LOAD) begin
        left     <= step_vld && (arb_idx == 2'd0);
        right    <= step_vld && (arb_idx == 2'd1);
        up       <= step_vld && (arb_idx == 2'd2);
        down     <= step_vld && (arb_idx == 2'd3);
        dir_code <= step_vld ? {1'b0, arb_idx} : 3'b100;
      end
    end
  end

endmodule

// File: tb/tb_player_move_ctrl.sv
// tb/tb_player_move_ctrl.sv - self-checking bench for player_move_ctrl against a behavioural model
module tb_player_move_ctrl;
  localparam int D  = 4;
  localparam int M  = 8;
  localparam int CW = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_start = 1'b0;
  logic       left, right, up, down, move_clock, running;
  logic [2:0] dir_code;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  player_move_ctrl #(.DEBOUNCE_CYC(D), .MOVE_DIV(M), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
    .btn_start(btn_start),
    .left(left), .right(right), .up(up), .down(down),
    .move_clock(move_clock), .dir_code(dir_code), .running(running)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: m_k = clock edges since reset, m_state 0 idle / 1 run / 2 pause,
  // m_owner -1 none else button index, exp_dir the direction code latched at load edges.
  bit [4:0] m_s1, m_s2, m_lvl;
  int       m_streak [5];
  int       m_owner, m_state, m_k, exp_dir;
  bit       m_start_prev;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0;
      for (int i = 0; i < 5; i++) m_streak[i] = 0;
      m_owner = -1; m_state = 0; m_k = 0; exp_dir = 4; m_start_prev = 0;
    end else begin
      int res, masked;
      bit rise;
      res = m_owner;
      if (res < 0) res = -1;
      else if (!m_lvl[res]) res = -1;
      if (res < 0)
        for (int i = 0; i < 4; i++) if (m_lvl[i] && res < 0) res = i;
      masked = (m_state == 1) ? res : -1;
      rise = m_lvl[4] && !m_start_prev;
      if (rise) m_state = (m_state == 1) ? 2 : 1;
      m_start_prev = m_lvl[4];
      m_owner = res;
`ifdef PLAYER_CTRL_DEBOUNCE_EN
      for (int i = 0; i < 5; i++) begin
        if (m_s2[i] != m_lvl[i]) begin
          m_streak[i]++;
          if (m_streak[i] == D) begin
            m_lvl[i] = m_s2[i];
            m_streak[i] = 0;
          end
        end else begin
          m_streak[i] = 0;
        end
      end
      m_s2 = m_s1;
`else
      m_s2 = m_s1;
      m_lvl = m_s2;
`endif
      m_s1 = {btn_start, btn_down, btn_up, btn_right, btn_left};
      m_k++;
      if (m_k % M == M - 1) exp_dir = (masked < 0) ? 4 : masked;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("left", left, int'(exp_dir == 0));
      chk("right", right, int'(exp_dir == 1));
      chk("up", up, int'(exp_dir == 2));
      chk("down", down, int'(exp_dir == 3));
      chk("dir_code", dir_code, exp_dir);
      chk("move_clock", move_clock, int'((m_k >= M) && (m_k % M < M / 2)));
      chk("running", running, int'(m_state == 1));
    end
  end

  task automatic start_pulse();
    btn_start = 1'b1;
    repeat (10) @(negedge clk);
    btn_start = 1'b0;
  endtask

  initial begin
    int got, per, hi, cnt, st;
    logic prev;
    bit [3:0] b;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_dir_code", dir_code, 4);
    chk("rst_move_clock", move_clock, 0);
    chk("rst_running", running, 0);
    chk("model_rst_dir", exp_dir, 4);

    // IDLE: a held direction must not produce a step
    btn_left = 1'b1;
    repeat (30) @(negedge clk);
    chk("idle_left", left, 0);
    chk("idle_dir_code", dir_code, 4);
    chk("idle_running", running, 0);

    got = 0;
    for (int i = 0; i < 20; i++) begin
      prev = move_clock;
      @(negedge clk);
      if (move_clock && !prev) begin got = 1; break; end
    end
    chk("mc_rise_found", got, 1);
    per = 0; hi = 0;
    for (int i = 0; i < 20; i++) begin
      hi += int'(move_clock);
      per++;
      prev = move_clock;
      @(negedge clk);
      if (move_clock && !prev) break;
    end
    chk("mc_period", per, 8);
    chk("mc_high", hi, 4);

    start_pulse();
    repeat (4) @(negedge clk);
    chk("run_after_start", running, 1);
    chk("model_run", m_state, 1);

    btn_left = 1'b0;
    btn_right = 1'b1;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (right) got = 1;
    end
    chk("right_granted", got, 1);
    chk("right_code", dir_code, 1);
    chk("right_before_rise", move_clock, 0);
    chk("model_right", exp_dir, 1);
    @(negedge clk);
    chk("right_mc_rise", move_clock, 1);
    st = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (right && dir_code == 3'b001) st++;
    end
    chk("right_hold", st, 6);

    // First-pressed wins: up keeps the grant while left is added
    btn_right = 1'b0;
    btn_up = 1'b1;
    repeat (20) @(negedge clk);
    btn_left = 1'b1;
    repeat (20) @(negedge clk);
    chk("up_kept", up, 1);
    chk("left_blocked", left, 0);
    btn_up = 1'b0;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (left) got = 1;
    end
    chk("left_after_up", got, 1);
    chk("up_released", up, 0);

    btn_left = 1'b0;
    repeat (20) @(negedge clk);
    chk("none_dir_code", dir_code, 4);

    btn_left = 1'b1;
    btn_down = 1'b1;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (left) got = 1;
    end
    chk("simul_left", got, 1);
    chk("simul_down", down, 0);
    btn_left = 1'b0;
    btn_down = 1'b0;
    repeat (20) @(negedge clk);

    btn_down = 1'b1;
    repeat (3) @(negedge clk);
    btn_down = 1'b0;
    cnt = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      cnt += int'(down);
    end
`ifdef PLAYER_CTRL_DEBOUNCE_EN
    chk("glitch_down", cnt, 0);
`endif

    // Pause masks directions from the next load edge
    btn_right = 1'b1;
    repeat (20) @(negedge clk);
    start_pulse();
    repeat (20) @(negedge clk);
    chk("pause_running", running, 0);
    chk("pause_right", right, 0);
    chk("pause_code", dir_code, 4);

    start_pulse();
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (right && move_clock) got = 1;
    end
    chk("resume_right_mc", got, 1);
    #1 reset = 1'b1;
    #1;
    chk("rst_async_mc", move_clock, 0);
    chk("rst_async_code", dir_code, 4);
    chk("rst_async_right", right, 0);
    chk("rst_async_running", running, 0);
    btn_right = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    while (!move_clock && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("first_rise_delay", cnt, M);

    // Randomized phase, checked every cycle by the model
    for (int seg = 0; seg < 300; seg++) begin
      b = 4'($urandom);
      btn_left  = b[0];
      btn_right = b[1];
      btn_up    = b[2];
      btn_down  = b[3];
      btn_start = ($urandom_range(0, 7) == 0);
      repeat ($urandom_range(1, 12)) @(negedge clk);
      if (seg == 150) begin
        #3 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
